// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 packet mux.
// The grant is held from first beat to the accepted 'last' beat.
// A grant is revoked only if the owner holds valid low for IDLE_TO cycles.
module mux2_rr_arbiter #(
  parameter int unsigned DW      = 8,
  parameter int unsigned IDLE_TO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a0_valid,
  input  logic [DW-1:0] a0_data,
  input  logic          a0_last,
  output logic          a0_ready,
  input  logic          a1_valid,
  input  logic [DW-1:0] a1_data,
  input  logic          a1_last,
  output logic          a1_ready,
  output logic          y_valid,
  output logic [DW-1:0] y_data,
  output logic          y_last,
  input  logic          y_ready,
  output logic          s,
  output logic          busy
);

  localparam int unsigned CW = $clog2(IDLE_TO + 1);
  localparam logic [CW-1:0] IDLE_TO_C = CW'(IDLE_TO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          s_q, s_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          own_valid;
  logic          own_last;

  // State, select, priority and idle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath mux and handshake outputs; only the owner sees y_ready.
  always_comb begin
    s        = s_q;
    busy     = (state_q != IDLE);
    y_data   = s_q ? a1_data : a0_data;
    y_last   = s_q ? a1_last : a0_last;
    y_valid  = 1'b0;
    a0_ready = 1'b0;
    a1_ready = 1'b0;
    unique case (state_q)
      GRANT0: begin
        y_valid  = a0_valid;
        a0_ready = y_ready;
      end
      GRANT1: begin
        y_valid  = a1_valid;
        a1_ready = y_ready;
      end
      default: ;
    endcase
  end

  // Arbitration, packet lock and idle revocation.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + CW'(1);
    // s_q identifies the owner while granted, so both grant states share one path.
    own_valid = s_q ? a1_valid : a0_valid;
    own_last  = s_q ? a1_last  : a0_last;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a0_valid && (!a1_valid || !prio_q)) begin
          state_d = GRANT0;
          s_d     = 1'b0;
        end else if (a1_valid) begin
          state_d = GRANT1;
          s_d     = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (own_valid) begin
          cnt_d = '0;
          if (y_ready && own_last) begin
            state_d = IDLE;
            prio_d  = ~s_q;
          end
        end else if (cnt_inc == IDLE_TO_C) begin
          state_d = IDLE;
          prio_d  = ~s_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: vector table plus multi-cycle sequences.
module tb_mux2_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a0_valid, a0_last, a0_ready;
  logic [7:0] a0_data;
  logic       a1_valid, a1_last, a1_ready;
  logic [7:0] a1_data;
  logic       y_valid, y_last, y_ready;
  logic [7:0] y_data;
  logic       s, busy;
  logic [13:0] outv;

  int tests;
  int fails;

  mux2_rr_arbiter #(.DW(8), .IDLE_TO(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0_valid(a0_valid), .a0_data(a0_data), .a0_last(a0_last), .a0_ready(a0_ready),
    .a1_valid(a1_valid), .a1_data(a1_data), .a1_last(a1_last), .a1_ready(a1_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .s(s), .busy(busy)
  );

  assign outv = {s, busy, y_valid, y_data, y_last, a0_ready, a1_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a0v;
    logic [7:0] a0d;
    logic       a0l;
    logic       a1v;
    logic [7:0] a1d;
    logic       a1l;
    logic       yr;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic a0v, input logic [7:0] a0d, input logic a0l,
                              input logic a1v, input logic [7:0] a1d, input logic a1l,
                              input logic yr, input logic es, input logic eb,
                              input logic eyv, input logic [7:0] eyd, input logic eyl,
                              input logic er0, input logic er1);
    vec_t v;
    v.a0v = a0v; v.a0d = a0d; v.a0l = a0l;
    v.a1v = a1v; v.a1d = a1d; v.a1l = a1l;
    v.yr  = yr;
    v.exp = {es, eb, eyv, eyd, eyl, er0, er1};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    a0_valid = 1'b0; a0_data = 8'h00; a0_last = 1'b0;
    a1_valid = 1'b0; a1_data = 8'h00; a1_last = 1'b0;
    y_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   beats;
    int   bad;
    int   exp_idx;
    int   idx0, idx1;
    logic exp_owner;
    logic [7:0] exp_d;

    tests = 0;
    fails = 0;
    idx0  = 0;
    idx1  = 0;

    // Reset values
    clear_inputs();
    rst_n = 1'b0;
    #3;
    chk("reset_outputs", 32'(outv), 32'(14'h0000));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table, applied cycle by cycle from a fresh reset
    //          a0v a0d    a0l a1v a1d    a1l yr  | s busy yv yd     yl r0 r1
    vecs[0]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1,   0, 0, 0, 8'h11, 0, 0, 0);
    vecs[1]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 1,   0, 1, 1, 8'h11, 0, 1, 0);
    vecs[2]  = mk(1, 8'h22, 0, 0, 8'h00, 0, 1,   0, 1, 1, 8'h22, 0, 1, 0);
    vecs[3]  = mk(1, 8'h33, 1, 0, 8'h00, 0, 1,   0, 1, 1, 8'h33, 1, 1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 0, 0, 0);
    vecs[5]  = mk(1, 8'h44, 1, 0, 8'h00, 0, 1,   0, 0, 0, 8'h44, 1, 0, 0);
    vecs[6]  = mk(1, 8'h44, 1, 0, 8'h00, 0, 1,   0, 1, 1, 8'h44, 1, 1, 0);
    vecs[7]  = mk(1, 8'h55, 1, 0, 8'h00, 0, 1,   0, 0, 0, 8'h55, 1, 0, 0);
    vecs[8]  = mk(1, 8'h55, 1, 0, 8'h00, 0, 1,   0, 1, 1, 8'h55, 1, 1, 0);
    vecs[9]  = mk(1, 8'h66, 0, 1, 8'h77, 0, 1,   0, 0, 0, 8'h66, 0, 0, 0);
    vecs[10] = mk(1, 8'h66, 0, 1, 8'h77, 0, 1,   1, 1, 1, 8'h77, 0, 0, 1);
    vecs[11] = mk(1, 8'h66, 0, 1, 8'h78, 1, 0,   1, 1, 1, 8'h78, 1, 0, 0);
    vecs[12] = mk(1, 8'h66, 0, 1, 8'h78, 1, 1,   1, 1, 1, 8'h78, 1, 0, 1);
    vecs[13] = mk(1, 8'h66, 0, 1, 8'h79, 0, 1,   1, 0, 0, 8'h79, 0, 0, 0);
    vecs[14] = mk(1, 8'h66, 0, 1, 8'h79, 0, 1,   0, 1, 1, 8'h66, 0, 1, 0);
    vecs[15] = mk(1, 8'h67, 1, 1, 8'h79, 0, 1,   0, 1, 1, 8'h67, 1, 1, 0);
    vecs[16] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a0_valid = vecs[i].a0v; a0_data = vecs[i].a0d; a0_last = vecs[i].a0l;
      a1_valid = vecs[i].a1v; a1_data = vecs[i].a1d; a1_last = vecs[i].a1l;
      y_ready  = vecs[i].yr;
      #1;
      chk($sformatf("vec%0d", i), 32'(outv), 32'(vecs[i].exp));
    end

    // Both requesters stream 2-beat packets: grants alternate 0,1,0,1
    do_reset();
    beats = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      a0_valid = 1'b1; a0_data = 8'(idx0);         a0_last = idx0[0];
      a1_valid = 1'b1; a1_data = 8'h80 | 8'(idx1); a1_last = idx1[0];
      y_ready  = 1'b1;
      #1;
      if (y_valid && y_ready) begin
        exp_owner = 1'((beats / 2) % 2);
        exp_idx   = (beats / 4) * 2 + (beats % 2);
        exp_d     = exp_owner ? (8'h80 | 8'(exp_idx)) : 8'(exp_idx);
        chk($sformatf("rr_owner_beat%0d", beats), 32'(s), 32'(exp_owner));
        chk($sformatf("rr_data_beat%0d", beats), 32'(y_data), 32'(exp_d));
        beats++;
      end
      if (a0_valid && a0_ready) idx0++;
      if (a1_valid && a1_ready) idx1++;
    end
    chk("rr_beat_count", 32'(beats), 32'd16);

    // a1 granted, sink stalls 40 cycles; a0 waits
    do_reset();
    @(negedge clk);
    a1_valid = 1'b1; a1_data = 8'hA5; a1_last = 1'b0; y_ready = 1'b0;
    @(negedge clk);
    a0_valid = 1'b1; a0_data = 8'h5A; a0_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!(s && busy && y_valid && !a1_ready && !a0_ready && y_data == 8'hA5)) bad++;
      @(negedge clk);
    end
    chk("stall_bad_cycles", 32'(bad), 32'd0);
    y_ready = 1'b1;
    #1;
    chk("stall_resume", 32'({s, busy, y_valid, y_data, a0_ready, a1_ready}),
        32'({1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1}));

    // a0 goes silent mid-packet: grant revoked after IDLE_TO cycles
    do_reset();
    @(negedge clk);
    a0_valid = 1'b1; a0_data = 8'h21; a0_last = 1'b0; y_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("revoke_first_beat", 32'({s, busy, a0_ready}), 32'({1'b0, 1'b1, 1'b1}));
    @(negedge clk);
    a0_valid = 1'b0;
    a1_valid = 1'b1; a1_data = 8'hB1; a1_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      #1;
      if (!(busy && !s && !y_valid && !a1_ready)) bad++;
    end
    chk("revoke_hold_14", 32'(bad), 32'd0);
    @(negedge clk);
    #1;
    chk("revoke_idle_at_15", 32'({busy, y_valid}), 32'({1'b0, 1'b0}));
    @(negedge clk);
    #1;
    chk("revoke_a1_granted", 32'({s, busy, y_valid, y_data, a1_ready}),
        32'({1'b1, 1'b1, 1'b1, 8'hB1, 1'b1}));

    // Asynchronous reset in the middle of a GRANT1 packet
    do_reset();
    @(negedge clk);
    a1_valid = 1'b1; a1_data = 8'hC3; a1_last = 1'b0; y_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("pre_reset_grant1", 32'({s, busy, a1_ready}), 32'({1'b1, 1'b1, 1'b1}));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({s, busy, y_valid, a0_ready, a1_ready}), 32'(5'b00000));
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
